// File: rtl/fir_tap_loader.sv
// Transmit end of the FIR tap-load daisy chain: turns host taps into counted beats for PE 0.
// Optional zero fill of unused PEs is enabled by defining FIR_TAP_LOADER_ZERO_FILL_EN.
module fir_tap_loader #(
  parameter int unsigned NUM_PE = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(NUM_PE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W:0]    num_taps,
  input  logic              flush,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              tap_out_valid,
  output logic [CNT_W-1:0]  tap_out_count,
  output logic [DATA_W-1:0] tap_out_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  localparam logic [CNT_W:0] NumPe = (CNT_W + 1)'(NUM_PE);
  localparam logic [CNT_W:0] One   = (CNT_W + 1)'(1);

  state_e              state_q, state_d;
  logic [CNT_W:0]      idx_q, idx_d;
  logic [CNT_W:0]      target_q, target_d;
  logic [CNT_W:0]      drain_q, drain_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [CNT_W:0]      idx_inc;
  logic                issue;
  logic                last;

  assign idx_inc = idx_q + One;
  assign s_ready = (state_q == StLoad) && (idx_q < target_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    drain_d  = drain_q;
    valid_d  = 1'b0;
    count_d  = '0;
    data_d   = '0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    issue    = 1'b0;
    last     = 1'b0;
    if (flush) begin
      state_d = StIdle;
      idx_d   = '0;
      drain_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if ((num_taps != '0) && (num_taps <= NumPe)) begin
              target_d = num_taps;
              idx_d    = '0;
              state_d  = StLoad;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        StLoad: begin
          if (s_valid && s_ready) begin
            issue  = 1'b1;
            data_d = s_data;
`ifdef FIR_TAP_LOADER_ZERO_FILL_EN
            last   = (idx_q == NumPe - One);
`else
            last   = (idx_inc == target_q);
`endif
          end
`ifdef FIR_TAP_LOADER_ZERO_FILL_EN
          // Host taps exhausted: pad the remaining PEs with zero taps.
          else if (idx_q >= target_q) begin
            issue = 1'b1;
            last  = (idx_q == NumPe - One);
          end
`endif
          if (issue) begin
            valid_d = 1'b1;
            count_d = idx_q[CNT_W-1:0];
            idx_d   = idx_inc;
          end
          // Drain length is highest issued count + 1, which covers the farthest hop.
          if (issue && last) begin
            state_d = StDrain;
            drain_d = idx_inc;
          end
        end
        StDrain: begin
          if (drain_q == '0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            drain_d = drain_q - One;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      target_q <= '0;
      drain_q  <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      drain_q  <= drain_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      data_q   <= data_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign tap_out_valid = valid_q;
  assign tap_out_count = count_q;
  assign tap_out_data  = data_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader (NUM_PE=16) with a registered PE-chain model.
module tb_fir_tap_loader;

`ifdef FIR_TAP_LOADER_ZERO_FILL_EN
  localparam bit ZeroFill = 1'b1;
`else
  localparam bit ZeroFill = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  num_taps = '0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        tap_out_valid;
  logic [3:0]  tap_out_count;
  logic [31:0] tap_out_data;
  logic        busy;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;
  int k;
  int beats;

  fir_tap_loader #(.NUM_PE(16), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_taps      (num_taps),
    .flush         (flush),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .tap_out_valid (tap_out_valid),
    .tap_out_count (tap_out_count),
    .tap_out_data  (tap_out_data),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  // PE chain: each hop is registered; a beat arriving with count 0 is latched by that PE.
  logic        sv [16];
  logic [3:0]  sc [16];
  logic [31:0] sd [16];
  logic [31:0] pe [16];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) sv[i] <= 1'b0;
    end else begin
      sv[0] <= tap_out_valid;
      sc[0] <= tap_out_count;
      sd[0] <= tap_out_data;
      for (int i = 1; i < 16; i++) begin
        sv[i] <= sv[i-1] && (sc[i-1] != 4'd0);
        sc[i] <= sc[i-1] - 4'd1;
        sd[i] <= sd[i-1];
      end
      for (int i = 0; i < 16; i++) if (sv[i] && (sc[i] == 4'd0)) pe[i] <= sd[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 64'(tap_out_valid), 64'd0);
    chk({tag, "_count"}, 64'(tap_out_count), 64'd0);
    chk({tag, "_data"}, 64'(tap_out_data), 64'd0);
    chk({tag, "_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_flags"}, 64'({done, error}), 64'd0);
  endtask

  task automatic wait_done(input int limit, output int cycles, output int nbeats);
    cycles = 0;
    nbeats = 0;
    while ((done !== 1'b1) && (cycles < limit)) begin
      tick();
      cycles++;
      if (tap_out_valid === 1'b1) nbeats++;
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_quiet("reset");
    rst_n = 1'b1;
    tick();

    // Reset mid-LOAD after three taps
    start = 1'b1;
    num_taps = 5'd16;
    tick();
    start = 1'b0;
    chk("ml_busy", 64'({busy, s_ready}), 64'b11);
    s_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      s_data = 32'h100 + 32'(j);
      tick();
    end
    chk("ml_beat2", 64'({tap_out_valid, tap_out_count, tap_out_data}), {1'b1, 4'd2, 32'h102});
    rst_n = 1'b0;
    #1;
    chk_quiet("ml_async");
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ml_after", 64'({busy, s_ready}), 64'b00);

    // Full 16-tap session, back-to-back
    start = 1'b1;
    num_taps = 5'd16;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      s_data = 32'h100 + 32'(j);
      tick();
      chk("full_beat", 64'({tap_out_valid, tap_out_count, tap_out_data}),
          {1'b1, 4'(j), 32'h100 + 32'(j)});
    end
    s_valid = 1'b0;
    chk("full_drain_ready", 64'({busy, s_ready}), 64'b10);
    wait_done(64, k, beats);
    chk("full_done_lat", 64'(k), 64'd17);
    chk("full_stray", 64'(beats), 64'd0);
    chk("full_busy_drop", 64'(busy), 64'd0);
    for (int j = 0; j < 16; j++) chk("full_pe", 64'(pe[j]), 64'(32'h100 + 32'(j)));

    // Four taps with s_valid toggled every other cycle
    start = 1'b1;
    num_taps = 5'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = (i % 2 == 0);
      s_data = 32'h200 + 32'(i);
      tick();
      if (i % 2 == 0)
        chk("tog_beat", 64'({tap_out_valid, tap_out_count, tap_out_data}),
            {1'b1, 4'(i / 2), 32'h200 + 32'(i)});
      else
        chk("tog_idle", 64'({tap_out_valid, tap_out_count, tap_out_data}), 64'd0);
    end
    s_valid = 1'b0;
    wait_done(64, k, beats);
    chk("tog_done_lat", 64'(k), ZeroFill ? 64'd29 : 64'd5);
    chk("tog_fill_beats", 64'(beats), ZeroFill ? 64'd12 : 64'd0);
    for (int j = 0; j < 4; j++) chk("tog_pe", 64'(pe[j]), 64'(32'h200 + 32'(2 * j)));
    chk("tog_pe4", 64'(pe[4]), ZeroFill ? 64'd0 : 64'h104);

    // Illegal tap counts
    start = 1'b1;
    num_taps = 5'd0;
    tick();
    chk("err0", 64'({error, busy, tap_out_valid}), 64'b100);
    start = 1'b0;
    tick();
    chk("err0_pulse", 64'(error), 64'd0);
    start = 1'b1;
    num_taps = 5'd17;
    tick();
    chk("err17", 64'({error, busy, tap_out_valid}), 64'b100);
    start = 1'b0;
    tick();
    chk("err17_pulse", 64'({error, busy}), 64'd0);

    // Flush on the third acceptance
    start = 1'b1;
    num_taps = 5'd8;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h300;
    tick();
    s_data = 32'h301;
    tick();
    s_data = 32'h302;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    s_valid = 1'b0;
    chk_quiet("flush");
    wait_done(20, k, beats);
    chk("flush_no_done", 64'(k), 64'd20);
    start = 1'b1;
    num_taps = 5'd2;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h400;
    tick();
    chk("post_beat0", 64'({tap_out_valid, tap_out_count, tap_out_data}), {1'b1, 4'd0, 32'h400});
    s_data = 32'h401;
    tick();
    chk("post_beat1", 64'({tap_out_valid, tap_out_count, tap_out_data}), {1'b1, 4'd1, 32'h401});
    s_valid = 1'b0;
    wait_done(64, k, beats);
    chk("post_done_lat", 64'(k), ZeroFill ? 64'd31 : 64'd3);

    // start during DRAIN is ignored
    start = 1'b1;
    num_taps = 5'd16;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      s_data = 32'h500 + 32'(j);
      tick();
    end
    s_valid = 1'b0;
    start = 1'b1;
    num_taps = 5'd3;
    tick();
    start = 1'b0;
    chk("drain_start", 64'({error, done, busy}), 64'b001);
    wait_done(64, k, beats);
    chk("drain_done_lat", 64'(k), 64'd16);
    tick();
    chk("drain_idle", 64'({busy, s_ready}), 64'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
